// File: rtl/soc_cycle_counter_pkg.sv
// Shared definitions for the SoC cycle counter controller.
// Holds the register map byte offsets, the CTRL/STATUS bit positions, the CTRL
// register layout and a helper that turns a bus byte address into a word offset.
package soc_cycle_counter_pkg;

  // Register byte offsets on the peripheral bus.
  localparam logic [4:0] CTRL_OFF   = 5'h00;
  localparam logic [4:0] STATUS_OFF = 5'h04;
  localparam logic [4:0] CNT_LO_OFF = 5'h08;
  localparam logic [4:0] CNT_HI_OFF = 5'h0C;
  localparam logic [4:0] CMP_LO_OFF = 5'h10;
  localparam logic [4:0] CMP_HI_OFF = 5'h14;
  localparam logic [4:0] PRESC_OFF  = 5'h18;

  // Register field positions.
  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_IE_BIT     = 1;
  localparam int unsigned STATUS_PEND_BIT = 0;

  typedef struct packed {
    logic ie;  // bit 1
    logic en;  // bit 0
  } ctrl_reg_t;

  // Byte lanes within a word are ignored.
  function automatic logic [4:0] word_off(input logic [4:0] addr);
    return {addr[4:2], 2'b00};
  endfunction

endpackage

// File: rtl/soc_cycle_counter_if.sv
// Peripheral bus bundle for the cycle counter controller.
//   req    : request strobe, accepted every cycle
//   we     : 1 = write, 0 = read
//   addr   : byte offset, bits [1:0] ignored
//   wdata  : write data
//   rdata  : read data, valid with rvalid (0 otherwise)
//   rvalid : response strobe, one cycle after each request
// master drives the request side, slave (the controller) drives the response.
interface soc_cycle_counter_if;
  logic        req;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (
    output req, we, addr, wdata,
    input  rdata, rvalid
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, rvalid
  );
endinterface

// File: rtl/soc_cycle_counter_prescaler.sv
// Prescaler for the cycle counter.
// Counts enabled cycles and emits a one-cycle tick each time the internal
// counter matches the programmed divide value, then restarts from zero.
//   i_clk    : clock
//   i_rst_n  : synchronous active-low reset
//   i_en     : counting enabled (CTRL.EN)
//   i_sleep  : freezes the prescaler while high
//   i_presc  : divide value; a tick every i_presc+1 enabled cycles
//   i_clr    : clears the prescaler counter (PRESC register write)
//   o_tick   : pulse that advances the main count
module soc_cycle_counter_prescaler
  import soc_cycle_counter_pkg::*;
#(
  parameter int unsigned PRESC_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_sleep,
  input  logic [PRESC_W-1:0] i_presc,
  input  logic               i_clr,
  output logic               o_tick
);

  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic               run;

  assign run = i_en & ~i_sleep;

  always_comb begin
    o_tick = run && (pcnt_q == i_presc);
    pcnt_d = pcnt_q;
    if (i_clr) begin
      pcnt_d = '0;
    end else if (run) begin
      pcnt_d = o_tick ? '0 : pcnt_q + {{(PRESC_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/soc_cycle_counter_ctrl.sv
// Memory-mapped controller for the SoC 64-bit cycle counter.
// Software enables counting, preloads either half of the count, programs a
// prescaler and a 64-bit compare value, and reads the count as a coherent
// pair: reading CNT_LO captures the upper word into a shadow returned by a
// later CNT_HI read. count >= compare sets a sticky PEND flag.
//   i_clk    : clock
//   i_rst_n  : synchronous active-low reset
//   i_sleep  : freezes prescaler and count while high
//   bus      : peripheral bus (slave side)
//   o_mcycle : current count, straight from the count register
//   o_irq    : registered PEND & IE
module soc_cycle_counter_ctrl
  import soc_cycle_counter_pkg::*;
#(
  parameter int unsigned PRESC_W = 16,
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_sleep,
  soc_cycle_counter_if.slave   bus,
  output logic [63:0]          o_mcycle,
  output logic                 o_irq
);

  ctrl_reg_t          ctrl_q, ctrl_d;
  logic               pend_q, pend_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [63:0]        cnt_q, cnt_d;
  logic [63:0]        cmp_q, cmp_d;
  logic [31:0]        shadow_q, shadow_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rvalid_q;
  logic               irq_q;

  logic               wr_en, rd_en;
  logic [4:0]         off;
  logic               presc_clr;
  logic               tick;
  logic               unused_addr;

  assign wr_en       = bus.req & bus.we;
  assign rd_en       = bus.req & ~bus.we;
  assign off         = word_off(bus.addr);
  assign unused_addr = ^bus.addr[1:0];

  soc_cycle_counter_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (ctrl_q.en),
    .i_sleep (i_sleep),
    .i_presc (presc_q),
    .i_clr   (presc_clr),
    .o_tick  (tick)
  );

  // Register writes and read data mux.
  always_comb begin
    ctrl_d    = ctrl_q;
    presc_d   = presc_q;
    cmp_d     = cmp_q;
    shadow_d  = shadow_q;
    rdata_d   = '0;
    presc_clr = 1'b0;

    if (wr_en) begin
      case (off)
        CTRL_OFF: begin
          ctrl_d.en = bus.wdata[CTRL_EN_BIT];
          ctrl_d.ie = bus.wdata[CTRL_IE_BIT];
        end
        CMP_LO_OFF: cmp_d[31:0]  = bus.wdata;
        CMP_HI_OFF: cmp_d[63:32] = bus.wdata;
        PRESC_OFF: begin
          presc_d   = bus.wdata[PRESC_W-1:0];
          presc_clr = 1'b1;
        end
        default: ;
      endcase
    end

    if (rd_en) begin
      case (off)
        CTRL_OFF: begin
          rdata_d[CTRL_EN_BIT] = ctrl_q.en;
          rdata_d[CTRL_IE_BIT] = ctrl_q.ie;
        end
        STATUS_OFF: rdata_d[STATUS_PEND_BIT] = pend_q;
        CNT_LO_OFF: begin
          rdata_d  = cnt_q[31:0];
          shadow_d = cnt_q[63:32];
        end
        CNT_HI_OFF: rdata_d = shadow_q;
        CMP_LO_OFF: rdata_d = cmp_q[31:0];
        CMP_HI_OFF: rdata_d = cmp_q[63:32];
        PRESC_OFF:  rdata_d[PRESC_W-1:0] = presc_q;
        default: ;
      endcase
    end
  end

  // A preload replaces one half and drops the same-cycle increment entirely,
  // so no carry leaks into or out of the written half.
  always_comb begin
    cnt_d = tick ? cnt_q + 64'd1 : cnt_q;
    if (wr_en && (off == CNT_LO_OFF)) begin
      cnt_d = {cnt_q[63:32], bus.wdata};
    end else if (wr_en && (off == CNT_HI_OFF)) begin
      cnt_d = {bus.wdata, cnt_q[31:0]};
    end
  end

  // Level-sensitive set beats a simultaneous write-1-to-clear.
  always_comb begin
    pend_d = pend_q;
    if (wr_en && (off == STATUS_OFF) && bus.wdata[STATUS_PEND_BIT]) begin
      pend_d = 1'b0;
    end
    if (cnt_q >= cmp_q) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ctrl_q   <= '0;
      pend_q   <= 1'b0;
      presc_q  <= '0;
      cnt_q    <= '0;
      cmp_q    <= CMP_RST;
      shadow_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      pend_q   <= pend_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      cmp_q    <= cmp_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
      rvalid_q <= bus.req;
      irq_q    <= pend_q & ctrl_q.ie;
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign o_mcycle   = cnt_q;
  assign o_irq      = irq_q;

endmodule

// File: tb/tb_soc_cycle_counter_ctrl.sv
// Directed bench for soc_cycle_counter_ctrl. Bus requests push their expected
// response into a scoreboard queue; a negedge monitor pops and compares each
// response as o_rvalid appears, including its one-cycle latency.
module tb_soc_cycle_counter_ctrl;
  import soc_cycle_counter_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        sleep = 1'b0;
  logic [63:0] mcycle;
  logic        irq;

  soc_cycle_counter_if bus_if();

  soc_cycle_counter_ctrl #(
    .PRESC_W (16),
    .CMP_RST (64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_sleep  (sleep),
    .bus      (bus_if),
    .o_mcycle (mcycle),
    .o_irq    (irq)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int unsigned issue;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Monitor: responses must arrive exactly one cycle after issue, in order.
  always @(negedge clk) begin
    exp_t e;
    if (bus_if.rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_rvalid: got rvalid=1 rdata=%08h, required no response", bus_if.rdata);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (bus_if.rdata !== e.data || cyc != e.issue + 1) begin
          n_err++;
          $display("FAIL %s: got rdata=%08h latency=%0d, required rdata=%08h latency=1",
                   e.name, bus_if.rdata, cyc - e.issue, e.data);
        end
      end
    end else begin
      n_cmp++;
      if (bus_if.rdata !== 32'h0 || bus_if.rvalid !== 1'b0) begin
        n_err++;
        $display("FAIL idle_bus: got rvalid=%b rdata=%08h, required rvalid=0 rdata=00000000",
                 bus_if.rvalid, bus_if.rdata);
      end
      if (sb.size() != 0 && cyc >= sb[0].issue + 1) begin
        e = sb.pop_front();
        n_cmp++;
        n_err++;
        $display("FAIL %s: got no rvalid, required rdata=%08h", e.name, e.data);
      end
    end
  end

  // Called at a negedge; returns at the following negedge.
  task automatic xfer(input logic w, input logic [4:0] a, input logic [31:0] d,
                      input logic [31:0] exp, input string name);
    exp_t e;
    bus_if.req   = 1'b1;
    bus_if.we    = w;
    bus_if.addr  = a;
    bus_if.wdata = d;
    e.data  = w ? 32'h0 : exp;
    e.issue = cyc;
    e.name  = name;
    sb.push_back(e);
    @(negedge clk);
    bus_if.req   = 1'b0;
    bus_if.we    = 1'b0;
    bus_if.addr  = '0;
    bus_if.wdata = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input string name);
    xfer(1'b1, a, d, 32'h0, name);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    xfer(1'b0, a, 32'h0, exp, name);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_reset [8];

  initial begin
    exp_reset = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
    bus_if.req   = 1'b0;
    bus_if.we    = 1'b0;
    bus_if.addr  = '0;
    bus_if.wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_mcycle", mcycle, 64'h0);
    check("reset_irq", {63'h0, irq}, 64'h0);
    check("reset_rvalid", {63'h0, bus_if.rvalid}, 64'h0);

    // Reset values of every offset, back to back.
    for (int i = 0; i < 8; i++) begin
      rd(5'(i * 4), exp_reset[i], $sformatf("reset_rd_%02h", i * 4));
    end

    // Prescale by 4: ticks on every 4th enabled cycle.
    wr(PRESC_OFF, 32'd3, "wr_presc3");
    rd(PRESC_OFF, 32'd3, "rd_presc3");
    wr(CTRL_OFF, 32'd1, "wr_en");
    repeat (39) @(negedge clk);
    rd(CNT_LO_OFF, 32'd9, "presc_cnt_after_39");
    sleep = 1'b1;
    repeat (4) @(negedge clk);
    rd(CNT_LO_OFF, 32'd10, "sleep_cnt_a");
    repeat (2) @(negedge clk);
    rd(CNT_LO_OFF, 32'd10, "sleep_cnt_b");
    check("sleep_mcycle", mcycle, 64'd10);
    sleep = 1'b0;
    repeat (4) @(negedge clk);
    rd(CNT_LO_OFF, 32'd11, "wake_cnt");

    // Coherent 64-bit read across the 32-bit carry.
    wr(CTRL_OFF, 32'd0, "wr_dis");
    wr(PRESC_OFF, 32'd0, "wr_presc0");
    wr(CNT_HI_OFF, 32'h0, "wr_cnt_hi0");
    wr(CNT_LO_OFF, 32'hFFFF_FFFE, "wr_cnt_lo_fffe");
    wr(CTRL_OFF, 32'd1, "wr_en2");
    rd(CNT_LO_OFF, 32'hFFFF_FFFE, "carry_lo_a");
    rd(CNT_HI_OFF, 32'h0, "carry_hi_a");
    rd(CNT_LO_OFF, 32'h0, "carry_lo_b");
    rd(CNT_HI_OFF, 32'h1, "carry_hi_b");
    check("carry_mcycle", mcycle, 64'h1_0000_0002);

    // 64-bit wrap; count >= all-ones compare also sets PEND.
    wr(CNT_HI_OFF, 32'hFFFF_FFFF, "wr_hi_ones");
    wr(CNT_LO_OFF, 32'hFFFF_FFFF, "wr_lo_ones");
    check("wrap_ones", mcycle, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    check("wrap_zero", mcycle, 64'h0);

    // Compare at 100 with interrupts enabled.
    wr(CTRL_OFF, 32'd0, "wr_dis2");
    wr(CNT_LO_OFF, 32'h0, "wr_lo0");
    wr(CMP_LO_OFF, 32'd100, "wr_cmp_lo");
    wr(CMP_HI_OFF, 32'h0, "wr_cmp_hi");
    rd(STATUS_OFF, 32'd1, "pend_from_wrap");
    wr(STATUS_OFF, 32'd1, "w1c_a");
    rd(STATUS_OFF, 32'd0, "pend_cleared");
    check("irq_ie0", {63'h0, irq}, 64'h0);
    wr(CTRL_OFF, 32'd3, "wr_en_ie");
    repeat (100) @(negedge clk);
    check("cmp_mcycle", mcycle, 64'd100);
    rd(STATUS_OFF, 32'd0, "pend_before");
    check("irq_before", {63'h0, irq}, 64'h0);
    rd(STATUS_OFF, 32'd1, "pend_set");
    check("irq_set", {63'h0, irq}, 64'h1);
    wr(STATUS_OFF, 32'd1, "w1c_while_hit");
    rd(STATUS_OFF, 32'd1, "pend_sticky");
    wr(CMP_HI_OFF, 32'hFFFF_FFFF, "wr_cmp_hi_ones");
    wr(STATUS_OFF, 32'd1, "w1c_b");
    check("irq_lag", {63'h0, irq}, 64'h1);
    @(negedge clk);
    check("irq_drop", {63'h0, irq}, 64'h0);
    rd(STATUS_OFF, 32'd0, "pend_off");

    // Preload beats a same-cycle increment; unmapped offset.
    wr(CNT_LO_OFF, 32'h1234_5678, "wr_lo_running");
    rd(CNT_LO_OFF, 32'h1234_5678, "preload_wins");
    rd(5'h1C, 32'h0, "unmapped_rd");
    wr(5'h1C, 32'hDEAD_BEEF, "unmapped_wr");
    wr(CTRL_OFF, 32'hFFFF_FFFF, "wr_ctrl_ones");
    rd(CTRL_OFF, 32'd3, "ctrl_masked");
    rd(PRESC_OFF, 32'd0, "presc_zero");

    // Reset during a request drops its response.
    bus_if.req  = 1'b1;
    bus_if.we   = 1'b0;
    bus_if.addr = CNT_LO_OFF;
    rst_n       = 1'b0;
    @(negedge clk);
    bus_if.req  = 1'b0;
    bus_if.addr = '0;
    check("rst_drop_rvalid", {63'h0, bus_if.rvalid}, 64'h0);
    check("rst_mcycle", mcycle, 64'h0);
    check("rst_irq", {63'h0, irq}, 64'h0);
    rst_n = 1'b1;
    rd(CMP_LO_OFF, 32'hFFFF_FFFF, "rst_cmp_lo");
    rd(CTRL_OFF, 32'h0, "rst_ctrl");
    rd(CNT_HI_OFF, 32'h0, "rst_shadow");

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
